// File: rtl/bt_pkg.sv
// Shared definitions for the balanced-ternary calculator sequencer:
// trit encodings, FSM states and operand-frame layout.
package bt_pkg;

  localparam int TRIT_W    = 2;
  localparam int NUM_TRITS = 4;
  localparam int FRAME_W   = TRIT_W * NUM_TRITS;

  localparam logic [TRIT_W-1:0] TRIT_NEG  = 2'b01;
  localparam logic [TRIT_W-1:0] TRIT_ZERO = 2'b11;
  localparam logic [TRIT_W-1:0] TRIT_POS  = 2'b10;
  localparam logic [TRIT_W-1:0] TRIT_ILL  = 2'b00;

  // Operand frame layout: arrival order x1, x0, y1, y0 fills low to high.
  localparam int X1_LSB = 0;
  localparam int X0_LSB = 2;
  localparam int Y1_LSB = 4;
  localparam int Y0_LSB = 6;

  localparam logic [FRAME_W-1:0] FRAME_RESET = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_HOLD,
    S_ERR
  } state_e;

  function automatic int slot_lsb(input logic [1:0] idx);
    case (idx)
      2'd0:    return X1_LSB;
      2'd1:    return X0_LSB;
      2'd2:    return Y1_LSB;
      default: return Y0_LSB;
    endcase
  endfunction

endpackage

// File: rtl/bt_calc_sequencer_if.sv
// Trit input stream and result handshake of the calculator sequencer.
interface bt_calc_sequencer_if;
  import bt_pkg::*;

  logic [TRIT_W-1:0]  trit_in;
  logic               trit_valid;
  logic               trit_ready;
  logic [FRAME_W-1:0] res_data;
  logic               res_err;
  logic               res_valid;
  logic               res_ready;

  modport master (
    output trit_in, trit_valid, res_ready,
    input  trit_ready, res_data, res_err, res_valid
  );

  modport slave (
    input  trit_in, trit_valid, res_ready,
    output trit_ready, res_data, res_err, res_valid
  );

endinterface

// File: rtl/bt_trit_check.sv
// Flags the one trit encoding that carries no value.
module bt_trit_check
  import bt_pkg::*;
(
  input  logic [TRIT_W-1:0] trit,
  output logic              illegal
);

  assign illegal = (trit == TRIT_ILL);

endmodule

// File: rtl/bt_calc_sequencer.sv
// Collects four trits into an operand frame for an external combinational
// calculator, waits EXEC_CYCLES, then hands the captured result off.
module bt_calc_sequencer
  import bt_pkg::*;
#(
  parameter int EXEC_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  bt_calc_sequencer_if.slave bus,
  output logic [FRAME_W-1:0] calc_in,
  input  logic [FRAME_W-1:0] calc_out,
  output logic [7:0]         op_count
);

  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES);
  localparam logic [1:0] LAST_IDX  = 2'(NUM_TRITS - 1);

  state_e             state_q, state_d;
  logic [1:0]         idx_q;
  logic [3:0]         cnt_q;
  logic               err_q;
  logic               ready_q;
  logic               res_err_q;
  logic [FRAME_W-1:0] res_data_q;
  logic               ill_trit;
  logic               accept;
  logic               last_trit;
  logic               exec_done;
  logic               handoff;
  logic               res_valid;

  bt_trit_check u_trit_check (
    .trit    (bus.trit_in),
    .illegal (ill_trit)
  );

  assign accept    = bus.trit_valid && ready_q;
  assign last_trit = accept && (idx_q == LAST_IDX);
  assign exec_done = (state_q == S_EXEC) && (cnt_q == 4'd0);
  assign handoff   = res_valid && bus.res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    res_valid = 1'b0;
    case (state_q)
      S_IDLE: if (accept) state_d = S_LOAD;
      S_LOAD: if (last_trit) state_d = S_EXEC;
      S_EXEC: if (cnt_q == 4'd0) state_d = err_q ? S_ERR : S_HOLD;
      S_HOLD, S_ERR: begin
        res_valid = 1'b1;
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // trit_ready is registered from the next state so it stays low during
  // reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q    <= 1'b0;
      calc_in    <= FRAME_RESET;
      idx_q      <= 2'd0;
      err_q      <= 1'b0;
      cnt_q      <= 4'd0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      op_count   <= 8'd0;
    end else begin
      ready_q <= (state_d == S_IDLE) || (state_d == S_LOAD);
      if (accept) begin
        calc_in[slot_lsb(idx_q) +: TRIT_W] <= bus.trit_in;
        idx_q <= idx_q + 2'd1;
        err_q <= err_q | ill_trit;
      end
      if (last_trit) begin
        cnt_q <= EXEC_LOAD;
      end else if ((state_q == S_EXEC) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (exec_done) begin
        res_data_q <= err_q ? '0 : calc_out;
        res_err_q  <= err_q;
      end
      if (handoff) begin
        op_count  <= op_count + 8'd1;
        err_q     <= 1'b0;
        res_err_q <= 1'b0;
        idx_q     <= 2'd0;
      end
    end
  end

  assign bus.trit_ready = ready_q;
  assign bus.res_valid  = res_valid;
  assign bus.res_data   = res_data_q;
  assign bus.res_err    = res_err_q;

endmodule
